// File: rtl/branch_resolve_queue_if.sv
// Predictor / resolution / BHT-update signal bundle around the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int unsigned PC_W = 9
);
  logic            pred_valid;
  logic [PC_W-1:0] pred_pc;
  logic            pred_taken;
  logic            pred_ready;
  logic            res_valid;
  logic            res_taken;
  logic            res_ready;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic            mispredict;
  logic            flush;

  // Fetch/execute side: presents predictions and resolutions, consumes updates.
  modport master (
    output pred_valid, pred_pc, pred_taken, res_valid, res_taken,
    input  pred_ready, res_ready, upd_valid, upd_pc, upd_taken, mispredict, flush
  );

  // Queue side.
  modport slave (
    input  pred_valid, pred_pc, pred_taken, res_valid, res_taken,
    output pred_ready, res_ready, upd_valid, upd_pc, upd_taken, mispredict, flush
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; trains the BHT on resolution and
// flushes wrong-path entries on a mispredict.
module branch_resolve_queue #(
  parameter int unsigned PC_W  = 9,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_resolve_queue_if.slave  bus,
  output logic [CNT_W-1:0]       total_cnt,
  output logic [CNT_W-1:0]       correct_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t            state, state_n;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic              pred_mem [DEPTH];
  logic [PTR_W-1:0]  head, head_n, tail, tail_n;
  logic [OCC_W-1:0]  count, count_n;

  logic              pred_ready, pred_ready_n;
  logic              res_ready, res_ready_n;
  logic              flush, flush_n;
  logic              upd_valid, upd_taken, mispredict;
  logic [PC_W-1:0]   upd_pc;

  logic              do_enq, do_res, miss, wr_en;

  // Next-state: accept/pop in RUN, clear everything on a mispredict, one FLUSH cycle.
  always_comb begin
    state_n = state;
    head_n  = head;
    tail_n  = tail;
    count_n = count;
    do_enq  = 1'b0;
    do_res  = 1'b0;
    miss    = 1'b0;
    wr_en   = 1'b0;
    case (state)
      RUN: begin
        do_enq = bus.pred_valid && pred_ready;
        do_res = bus.res_valid && res_ready;
        miss   = do_res && (bus.res_taken != pred_mem[head]);
        if (miss) begin
          state_n = FLUSH;
          head_n  = '0;
          tail_n  = '0;
          count_n = '0;
        end else begin
          wr_en = do_enq;
          if (do_enq) tail_n = tail + PTR_W'(1);
          if (do_res) head_n = head + PTR_W'(1);
          count_n = count + OCC_W'(do_enq) - OCC_W'(do_res);
        end
      end
      FLUSH: state_n = RUN;
    endcase
    // Ready flags are registered from the next occupancy; a full queue never bypasses.
    pred_ready_n = (state_n == RUN) && (count_n < OCC_W'(DEPTH));
    res_ready_n  = (state_n == RUN) && (count_n != '0);
    flush_n      = (state_n == FLUSH);
  end

  // State, pointers, registered outputs and saturating statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      pred_ready  <= 1'b1;
      res_ready   <= 1'b0;
      flush       <= 1'b0;
      upd_valid   <= 1'b0;
      upd_pc      <= '0;
      upd_taken   <= 1'b0;
      mispredict  <= 1'b0;
      total_cnt   <= '0;
      correct_cnt <= '0;
    end else begin
      state      <= state_n;
      head       <= head_n;
      tail       <= tail_n;
      count      <= count_n;
      pred_ready <= pred_ready_n;
      res_ready  <= res_ready_n;
      flush      <= flush_n;
      upd_valid  <= do_res;
      mispredict <= miss;
      if (do_res) begin
        upd_pc    <= pc_mem[head];
        upd_taken <= bus.res_taken;
        if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
        if (!miss && (correct_cnt != '1)) correct_cnt <= correct_cnt + CNT_W'(1);
      end
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail]   <= bus.pred_pc;
      pred_mem[tail] <= bus.pred_taken;
    end
  end

  assign bus.pred_ready = pred_ready;
  assign bus.res_ready  = res_ready;
  assign bus.flush      = flush;
  assign bus.upd_valid  = upd_valid;
  assign bus.upd_pc     = upd_pc;
  assign bus.upd_taken  = upd_taken;
  assign bus.mispredict = mispredict;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with a reference queue model and an update scoreboard.
module tb_branch_resolve_queue;
  localparam int unsigned PC_W  = 9;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned MAXC  = (1 << CNT_W) - 1;

  typedef struct { logic [PC_W-1:0] pc; logic pred; } ent_t;
  typedef struct { logic [PC_W-1:0] pc; logic taken; logic mis; } exp_t;

  logic clk;
  logic reset;
  logic [CNT_W-1:0] total_cnt, correct_cnt;

  branch_resolve_queue_if #(.PC_W(PC_W)) bus ();

  branch_resolve_queue #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .total_cnt   (total_cnt),
    .correct_cnt (correct_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_bad   = 0;
  ent_t mq[$];
  exp_t sb[$];
  logic m_flush;
  int   m_total, m_correct;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.pred_valid = 1'b0; bus.pred_pc = '0; bus.pred_taken = 1'b0;
    bus.res_valid = 1'b0; bus.res_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mq.delete(); sb.delete();
    m_flush = 1'b0; m_total = 0; m_correct = 0;
    chk("rst_pred_ready", 32'(bus.pred_ready), 32'd1);
    chk("rst_res_ready",  32'(bus.res_ready),  32'd0);
    chk("rst_upd_valid",  32'(bus.upd_valid),  32'd0);
    chk("rst_flush",      32'(bus.flush),      32'd0);
    chk("rst_total",      32'(total_cnt),      32'd0);
    chk("rst_correct",    32'(correct_cnt),    32'd0);
  endtask

  // One clock of stimulus: model predicts acceptance, scoreboard holds the expected update.
  task automatic cyc(input logic pv, input logic [PC_W-1:0] ppc, input logic pt,
                     input logic rv, input logic rt);
    logic mp_ready, mr_ready, mis;
    ent_t h;
    exp_t e;
    bus.pred_valid = pv; bus.pred_pc = ppc; bus.pred_taken = pt;
    bus.res_valid = rv;  bus.res_taken = rt;
    mp_ready = !m_flush && (mq.size() < int'(DEPTH));
    mr_ready = !m_flush && (mq.size() > 0);
    mis = 1'b0;
    if (rv && mr_ready) begin
      h = mq.pop_front();
      mis = (rt != h.pred);
      sb.push_back('{pc: h.pc, taken: rt, mis: mis});
      if (m_total < int'(MAXC)) m_total++;
      if (!mis && m_correct < int'(MAXC)) m_correct++;
    end
    if (mis) mq.delete();
    else if (pv && mp_ready) mq.push_back('{pc: ppc, pred: pt});
    m_flush = mis;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("upd_valid",  32'(bus.upd_valid),  32'd1);
      chk("upd_pc",     32'(bus.upd_pc),     32'(e.pc));
      chk("upd_taken",  32'(bus.upd_taken),  32'(e.taken));
      chk("mispredict", 32'(bus.mispredict), 32'(e.mis));
    end else begin
      chk("upd_idle",   32'(bus.upd_valid),  32'd0);
      chk("mis_idle",   32'(bus.mispredict), 32'd0);
    end
    chk("pred_ready", 32'(bus.pred_ready), 32'(!m_flush && (mq.size() < int'(DEPTH))));
    chk("res_ready",  32'(bus.res_ready),  32'(!m_flush && (mq.size() > 0)));
    chk("flush",      32'(bus.flush),      32'(m_flush));
    chk("total_cnt",  32'(total_cnt),      32'(m_total));
    chk("correct_cnt",32'(correct_cnt),    32'(m_correct));
  endtask

  initial begin
    logic t;
    do_reset();

    // Fill to DEPTH, then an ignored fifth prediction.
    for (int i = 0; i < 4; i++) cyc(1'b1, PC_W'(10 + i), 1'b1, 1'b0, 1'b0);
    chk("fill_full", 32'(bus.pred_ready), 32'd0);
    cyc(1'b1, PC_W'(14), 1'b1, 1'b0, 1'b0);

    // Correct resolve while full with a blocked enqueue, then drain.
    cyc(1'b1, PC_W'(15), 1'b1, 1'b1, 1'b1);
    chk("full_upd_pc", 32'(bus.upd_pc), 32'd10);
    chk("full_correct", 32'(correct_cnt), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Mispredict with a simultaneous wrong-path enqueue; inputs during FLUSH are ignored.
    cyc(1'b1, PC_W'(20), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, PC_W'(21), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, PC_W'(22), 1'b0, 1'b1, 1'b0);
    chk("mis_pulse", 32'(bus.mispredict), 32'd1);
    chk("mis_flush", 32'(bus.flush), 32'd1);
    chk("mis_upd_pc", 32'(bus.upd_pc), 32'd20);
    cyc(1'b1, PC_W'(23), 1'b1, 1'b1, 1'b1);
    chk("post_flush_empty", 32'(bus.res_ready), 32'd0);

    // Resolve on an empty queue does nothing.
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

    // Ten enqueue/resolve pairs across pointer wrap, mostly overlapped.
    cyc(1'b1, PC_W'(100), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 10; i++) begin
      t = mq[0].pred;
      cyc(1'b1, PC_W'(100 + i), 1'(i), 1'b1, t);
    end
    t = mq[0].pred;
    cyc(1'b0, '0, 1'b0, 1'b1, t);
    chk("wrap_total", 32'(total_cnt), 32'd15);

    // Saturation: twenty correct resolves from a fresh reset.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, PC_W'(200 + i), 1'b1, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
    end
    chk("sat_total", 32'(total_cnt), 32'd15);
    chk("sat_correct", 32'(correct_cnt), 32'd15);

    // Reset mid-operation discards queued entries.
    cyc(1'b1, PC_W'(300), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, PC_W'(301), 1'b1, 1'b0, 1'b0);
    do_reset();
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
